// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage:
// control kinds, result-select codes and the writeback entry type.
package alu_result_stage_pkg;

    localparam logic [1:0] CTRL_NONE   = 2'd0;
    localparam logic [1:0] CTRL_BRANCH = 2'd1;
    localparam logic [1:0] CTRL_JAL    = 2'd2;
    localparam logic [1:0] CTRL_JALR   = 2'd3;

    localparam logic [31:0] RES_ADD1 = 32'd0;
    localparam logic [31:0] RES_SUB  = 32'd1;
    localparam logic [31:0] RES_SLT  = 32'd2;
    localparam logic [31:0] RES_SLTU = 32'd3;
    localparam logic [31:0] RES_XOR  = 32'd4;
    localparam logic [31:0] RES_OR   = 32'd5;
    localparam logic [31:0] RES_AND  = 32'd6;
    localparam logic [31:0] RES_SLL  = 32'd7;
    localparam logic [31:0] RES_SRL  = 32'd8;
    localparam logic [31:0] RES_SRA  = 32'd9;
    localparam logic [31:0] RES_PCINC = 32'd10;
    localparam logic [31:0] RES_ADD2 = 32'd11;

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/alu_result_stage_wb_skid_buffer.sv
// Two-entry valid/ready skid buffer; MAIN drives the outputs,
// SKID catches one entry while MAIN is stalled.
module wb_skid_buffer #(
    parameter type T = logic [31:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic r_main_v;
    logic r_skid_v;
    logic r_in_ready;
    T     r_main;
    T     r_skid;
    logic w_push;
    logic w_fire;

    assign w_push    = in_valid && r_in_ready;
    assign w_fire    = r_main_v && out_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_main_v;
    assign out_data  = r_main;

    // Occupancy and entry movement; in_ready tracks "SKID empty next cycle".
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
            if (rst) begin
                r_main <= '0;
                r_skid <= '0;
            end
        end else if (!r_main_v) begin
            if (w_push) begin
                r_main   <= in_data;
                r_main_v <= 1'b1;
            end
        end else if (r_skid_v) begin
            if (w_fire) begin
                r_main     <= r_skid;
                r_skid_v   <= 1'b0;
                r_in_ready <= 1'b1;
            end
        end else if (w_fire) begin
            r_main_v <= w_push;
            if (w_push) begin
                r_main <= in_data;
            end
        end else if (w_push) begin
            r_skid     <= in_data;
            r_skid_v   <= 1'b1;
            r_in_ready <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: picks the ALU result, resolves
// branch/jump redirects and queues the writeback entry.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int RES_SEL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [RES_SEL_W-1:0] res_sel,
    input  logic [1:0]           ctrl,
    input  logic [4:0]           rd,
    input  logic                 rd_we,
    input  logic [31:0]          pc_inc,
    input  logic [31:0]          add_1_o,
    input  logic [31:0]          add_2_o,
    input  logic [31:0]          pc_mod_o,
    input  logic [31:0]          sub_o,
    input  logic [31:0]          slt_o,
    input  logic [31:0]          sltu_o,
    input  logic [31:0]          xor_o,
    input  logic [31:0]          or_o,
    input  logic [31:0]          and_o,
    input  logic [31:0]          sll_o,
    input  logic [31:0]          srl_o,
    input  logic [31:0]          sra_o,
    input  logic                 cmp_o,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4:0]           wb_rd,
    output logic                 wb_we,
    output logic [31:0]          wb_data,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc
);

    logic [31:0] w_sel;
    logic [31:0] w_sel_data;
    logic        w_take;
    logic [31:0] w_target;
    logic        w_accept;
    logic        w_buf_ready;
    wb_entry_t   w_entry;
    wb_entry_t   w_out;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;

    assign w_sel    = 32'(res_sel);
    assign w_accept = in_valid && w_buf_ready && !flush && !rst;
    assign in_ready = w_buf_ready;

    // Result-bus mux; unused codes read as zero.
    always_comb begin
        w_sel_data = '0;
        case (w_sel)
            RES_ADD1:  w_sel_data = add_1_o;
            RES_SUB:   w_sel_data = sub_o;
            RES_SLT:   w_sel_data = slt_o;
            RES_SLTU:  w_sel_data = sltu_o;
            RES_XOR:   w_sel_data = xor_o;
            RES_OR:    w_sel_data = or_o;
            RES_AND:   w_sel_data = and_o;
            RES_SLL:   w_sel_data = sll_o;
            RES_SRL:   w_sel_data = srl_o;
            RES_SRA:   w_sel_data = sra_o;
            RES_PCINC: w_sel_data = pc_inc;
            RES_ADD2:  w_sel_data = add_2_o;
            default:   w_sel_data = '0;
        endcase
    end

    // Control resolution: redirect decision, target and entry shaping.
    always_comb begin
        w_take        = 1'b0;
        w_target      = '0;
        w_entry.rd    = rd;
        w_entry.we    = rd_we && (rd != 5'd0);
        w_entry.data  = w_sel_data;
        case (ctrl)
            CTRL_BRANCH: begin
                w_take     = cmp_o;
                w_target   = add_2_o;
                w_entry.we = 1'b0;
            end
            CTRL_JAL: begin
                w_take       = 1'b1;
                w_target     = add_2_o;
                w_entry.data = pc_inc;
            end
            CTRL_JALR: begin
                w_take       = 1'b1;
                w_target     = pc_mod_o;
                w_entry.data = pc_inc;
            end
            default: begin
                w_take = 1'b0;
            end
        endcase
    end

    // Redirect pulse for the cycle after an accepted taken branch/jump.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_accept && w_take;
            if (w_accept && w_take) begin
                r_redirect_pc <= w_target;
            end
        end
    end

    wb_skid_buffer #(
        .T(wb_entry_t)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (w_accept),
        .in_ready  (w_buf_ready),
        .in_data   (w_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out)
    );

    assign wb_rd          = w_out.rd;
    assign wb_we          = w_out.we;
    assign wb_data        = w_out.data;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios
// followed by random traffic against a queue-based reference model.
module tb_alu_result_stage;
    import alu_result_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  res_sel;
    logic [1:0]  ctrl;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] bus [12];
    logic [31:0] pc_mod;
    logic        cmp;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int errors = 0;
    int checks = 0;

    wb_entry_t   mq[$];
    logic        m_in_ready = 1'b1;
    logic        m_rv = 1'b0;
    logic [31:0] m_rpc = '0;

    always #5 clk = ~clk;

    alu_result_stage #(.RES_SEL_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .res_sel(res_sel), .ctrl(ctrl), .rd(rd), .rd_we(rd_we),
        .pc_inc(bus[10]), .add_1_o(bus[0]), .add_2_o(bus[11]),
        .pc_mod_o(pc_mod), .sub_o(bus[1]), .slt_o(bus[2]),
        .sltu_o(bus[3]), .xor_o(bus[4]), .or_o(bus[5]),
        .and_o(bus[6]), .sll_o(bus[7]), .srl_o(bus[8]),
        .sra_o(bus[9]), .cmp_o(cmp),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(m_in_ready));
        chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
        if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
        if (mq.size() > 0) begin
            chk("wb_rd", 32'(wb_rd), 32'(mq[0].rd));
            chk("wb_we", 32'(wb_we), 32'(mq[0].we));
            chk("wb_data", wb_data, mq[0].data);
        end
    endtask

    // One clock: predict from current inputs, advance, compare at negedge.
    task automatic tick();
        bit acc, fire, take;
        wb_entry_t e;
        logic [31:0] tgt;
        acc  = in_valid && m_in_ready && !flush && !rst;
        fire = (mq.size() > 0) && out_ready;
        e.rd = rd;
        if (ctrl == 2'd2 || ctrl == 2'd3) e.data = bus[10];
        else if (res_sel < 4'd12) e.data = bus[res_sel];
        else e.data = 32'h0;
        e.we = rd_we && rd != 5'd0 && ctrl != 2'd1;
        take = (ctrl == 2'd1 && cmp) || ctrl == 2'd2 || ctrl == 2'd3;
        tgt  = (ctrl == 2'd3) ? pc_mod : bus[11];
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
            m_rv = 1'b0;
            if (rst) m_rpc = '0;
        end else begin
            if (fire) void'(mq.pop_front());
            if (acc) mq.push_back(e);
            m_rv = acc && take;
            if (acc && take) m_rpc = tgt;
        end
        m_in_ready = mq.size() < 2;
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_in();
        for (int i = 0; i < 12; i++) bus[i] = $urandom;
        pc_mod  = $urandom;
        cmp     = 1'($urandom_range(0, 1));
        res_sel = 4'($urandom_range(0, 15));
        ctrl    = 2'($urandom_range(0, 3));
        rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        rd_we   = 1'($urandom_range(0, 1));
    endtask

    initial begin
        rand_in();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // back-to-back XOR
        in_valid = 1'b1; ctrl = 2'd0; res_sel = 4'd4; rd = 5'd3; rd_we = 1'b1;
        bus[4] = 32'hF0F0_0000;
        tick();
        chk("xor_data", wb_data, 32'hF0F0_0000);
        for (int i = 0; i < 3; i++) begin
            bus[4] = 32'h1111_0000 + 32'(i);
            tick();
            chk("xor_stream_ready", 32'(in_ready), 32'd1);
        end

        // taken branch
        ctrl = 2'd1; cmp = 1'b1; bus[11] = 32'h0000_0100; rd = 5'd5;
        tick();
        chk("br_redirect_pc", redirect_pc, 32'h100);
        chk("br_we", 32'(wb_we), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("br_pulse_end", 32'(redirect_valid), 32'd0);

        // JALR
        in_valid = 1'b1; ctrl = 2'd3; pc_mod = 32'h0000_2000;
        bus[10] = 32'h0000_1004; rd = 5'd1; rd_we = 1'b1;
        tick();
        chk("jalr_pc", redirect_pc, 32'h2000);
        chk("jalr_data", wb_data, 32'h1004);
        chk("jalr_we", 32'(wb_we), 32'd1);
        in_valid = 1'b0;
        tick();

        // stall with three offers
        out_ready = 1'b0; in_valid = 1'b1; ctrl = 2'd0; res_sel = 4'd0;
        rd = 5'd7;
        for (int i = 0; i < 3; i++) begin
            bus[0] = 32'hA000_0000 + 32'(i);
            tick();
        end
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_main", wb_data, 32'hA000_0000);
        out_ready = 1'b1;
        tick();
        chk("drain_second", wb_data, 32'hA000_0001);
        tick();
        chk("third_accepted", wb_data, 32'hA000_0002);
        in_valid = 1'b0;
        tick();

        // rd=0 and unused select code
        in_valid = 1'b1; rd = 5'd0; rd_we = 1'b1; res_sel = 4'd0;
        tick();
        chk("rd0_we", 32'(wb_we), 32'd0);
        rd = 5'd9; res_sel = 4'd13;
        tick();
        chk("sel13_data", wb_data, 32'd0);

        // flush in TWO with JAL input
        out_ready = 1'b0; res_sel = 4'd5;
        tick(); tick();
        chk("two_in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1; ctrl = 2'd2;
        tick();
        flush = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_redirect", 32'(redirect_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);

        // reset mid-stall
        ctrl = 2'd0;
        tick(); tick();
        rst = 1'b1; ctrl = 2'd2;
        tick();
        rst = 1'b0;
        chk("rst_stall_out_valid", 32'(out_valid), 32'd0);
        chk("rst_stall_redirect", 32'(redirect_valid), 32'd0);
        chk("rst_stall_in_ready", 32'(in_ready), 32'd1);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            rand_in();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Execute-to-writeback stage placed directly downstream of the combinational `alu`. It selects one of the `alu` result buses per instruction, resolves branch and jump control flow into a PC redirect, and registers the outcome behind a valid/ready handshake. A two-entry skid buffer lets writeback stall without stalling fetch on the same cycle.

## Interface
- `RES_SEL_W`, default 4: width of the result-select code.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous kill of all held entries and of the current input.
- `in_valid`  in  1  upstream offers an instruction.
- `in_ready`  out  1  registered; stage can accept an instruction this cycle.
- `res_sel`  in  RES_SEL_W  result-select code (see Operation).
- `ctrl`  in  2  control kind: 0 NONE, 1 BRANCH, 2 JAL, 3 JALR.
- `rd`  in  5  destination register index.
- `rd_we`  in  1  instruction writes `rd`.
- `pc_inc`, `add_1_o`, `add_2_o`, `pc_mod_o`, `sub_o`, `slt_o`, `sltu_o`, `xor_o`, `or_o`, `and_o`, `sll_o`, `srl_o`, `sra_o`  in  32 each  `alu` result buses.
- `cmp_o`  in  1  `alu` branch-condition result.
- `out_valid`  out  1  a writeback entry is presented.
- `out_ready`  in  1  downstream accepts the entry.
- `wb_rd`  out  5  destination index of the presented entry.
- `wb_we`  out  1  write enable of the presented entry.
- `wb_data`  out  32  write data of the presented entry.
- `redirect_valid`  out  1  one-cycle pulse requesting a PC change.
- `redirect_pc`  out  32  target PC; meaningful only while `redirect_valid` is high.

## Operation
- Accept: `in_valid && in_ready && !flush && !rst`.
- `res_sel` codes: 0 `add_1_o`, 1 `sub_o`, 2 `slt_o`, 3 `sltu_o`, 4 `xor_o`, 5 `or_o`, 6 `and_o`, 7 `sll_o`, 8 `srl_o`, 9 `sra_o`, 10 `pc_inc`, 11 `add_2_o`. Codes 12–15 select `32'h0`.
- When `ctrl` is JAL or JALR, `wb_data` is `pc_inc` and `res_sel` is ignored.
- When `ctrl` is BRANCH, `wb_we` is forced to 0.
- `wb_we` is forced to 0 whenever `rd == 0`.
- Redirect on accept:
  - BRANCH with `cmp_o=1`: target `add_2_o`.
  - JAL: target `add_2_o`.
  - JALR: target `pc_mod_o`.
  - NONE, or BRANCH with `cmp_o=0`: no redirect.
- Buffer entries: MAIN (drives outputs) and SKID. States:
  - EMPTY to ONE on accept.
  - ONE to EMPTY on output fire with no accept.
  - ONE to TWO on accept while MAIN is held (`out_ready=0`); the new entry goes to SKID.
  - TWO to ONE on output fire; SKID moves to MAIN.
- Entries leave in program order.
- `in_ready` is registered as "SKID will be empty next cycle". It is low only in TWO, or when entering TWO.

## Timing
- Latency: an instruction accepted in cycle N appears on `out_valid` and `wb_*` in cycle N+1 if the stage was EMPTY, or when MAIN fired in cycle N.
- Redirect: `redirect_valid` is high for exactly cycle N+1 after an accept in cycle N. It is independent of `out_ready` and buffer occupancy.
- Full throughput: with `out_ready` held high, one accept and one output fire per cycle, and `in_ready` stays 1.
- Simultaneous accept and output fire in ONE: stay in ONE; MAIN is replaced by the new entry.
- `flush`: next cycle EMPTY, `out_valid=0`, `redirect_valid=0`. The input presented in the flush cycle is dropped. Flush takes priority over accept and over a MAIN-held entry.
- `out_valid` high with `out_ready` low: `wb_rd`, `wb_we` and `wb_data` are held stable.
- Reset values: `out_valid=0`, `wb_rd=0`, `wb_we=0`, `wb_data=0`, `redirect_valid=0`, `redirect_pc=0`, `in_ready=1`, state EMPTY.
- Handshakes are ignored while `rst` is high.
- Reset mid-stall discards both entries.

## Structure
- Shared package holds:
  - `ctrl` kind constants: `CTRL_NONE`, `CTRL_BRANCH`, `CTRL_JAL`, `CTRL_JALR`.
  - `res_sel` codes: `RES_ADD1` … `RES_ADD2`.
  - The packed writeback-entry type: `rd`, `we`, `data`.
- One sub-module, `wb_skid_buffer`: a generic two-entry valid/ready skid buffer over the entry type.
- The top level holds only result-select, control resolution and the redirect register.

## Test plan
- Back-to-back ALU ops, `out_ready=1`: `res_sel=4` with `xor_o=32'hF0F0_0000` → `wb_data=32'hF0F0_0000` next cycle, `in_ready` stays 1, one output per cycle.
- BRANCH with `cmp_o=1`, `add_2_o=32'h0000_0100`, `rd=5`, `rd_we=1` → `redirect_valid` pulses one cycle with `redirect_pc=32'h100`; `wb_we=0`.
- JALR with `pc_mod_o=32'h0000_2000`, `pc_inc=32'h0000_1004`, `rd=1` → `redirect_pc=32'h2000`, `wb_data=32'h1004`, `wb_we=1`.
- Stall: `out_ready=0`, three accepts offered → two accepted, `in_ready` falls after the second; raising `out_ready` drains both in order, then the third is accepted.
- `rd=0`, `rd_we=1`, `res_sel=0` → `wb_we=0`. `res_sel=13` → `wb_data=0`.
- Flush in TWO, coincident with a valid JAL input → next cycle `out_valid=0`, `redirect_valid=0`, `in_ready=1`. Reset mid-stall gives the same result.
